// File: rtl/arith_op_controller_if.sv
// -----------------------------------------------------------------------------
// arith_op_controller_if
// Purpose : bundles every non-clock/reset signal of arith_op_controller:
//           the decode request, the register-file read/write ports and the
//           two strobe/busy channels to the external adder.
// Modports:
//   master - the controller (drives rs1/rs2/rd/wr_data/we, status,
//            add_a/add_b/add_stb, sum_busy, next_pc)
//   slave  - the surrounding decode / register file / adder
// Parameters: DATA_W operand width, REG_AW register address width,
//             PC_W program-counter width.
// -----------------------------------------------------------------------------
interface arith_op_controller_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int PC_W   = 5
);
   // decode request
   logic              start;
   logic [1:0]        op_type;
   logic              op_sub;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   next_pc;
   logic [REG_AW-1:0] src1_addr;
   logic [REG_AW-1:0] src2_addr;
   logic [REG_AW-1:0] dst_addr;
   logic [DATA_W-1:0] imm;
   // register file
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [REG_AW-1:0] rd;
   logic [DATA_W-1:0] src1_val;
   logic [DATA_W-1:0] src2_val;
   logic [DATA_W-1:0] wr_data;
   logic              we;
   // status
   logic              busy;
   logic              done;
   logic              err;
   // adder input channel
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic              add_stb;
   logic              add_busy;
   // adder result channel
   logic [DATA_W-1:0] sum;
   logic              sum_stb;
   logic              sum_busy;

   modport master (
      input  start, op_type, op_sub, pc, src1_addr, src2_addr, dst_addr, imm,
      input  src1_val, src2_val, add_busy, sum, sum_stb,
      output next_pc, rs1, rs2, rd, wr_data, we, busy, done, err,
      output add_a, add_b, add_stb, sum_busy
   );

   modport slave (
      output start, op_type, op_sub, pc, src1_addr, src2_addr, dst_addr, imm,
      output src1_val, src2_val, add_busy, sum, sum_stb,
      input  next_pc, rs1, rs2, rd, wr_data, we, busy, done, err,
      input  add_a, add_b, add_stb, sum_busy
   );
endinterface

// File: rtl/arith_op_controller.sv
// -----------------------------------------------------------------------------
// arith_op_controller
// Purpose : sequences one add/subtract instruction: reads two operands from
//           the register file, hands them to an external adder over a
//           strobe/busy channel, waits for the result, writes it back and
//           reports done/err plus the next program counter.
// Ports   :
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - arith_op_controller_if.master (decode, register file, adder,
//           status; see the interface file)
// Parameters: DATA_W, REG_AW, PC_W widths; TIMEOUT cycles allowed in
//           ISSUE+WAIT before abort (>=2); ZERO_WP suppresses writes to r0.
// -----------------------------------------------------------------------------
module arith_op_controller #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int PC_W    = 5,
   parameter int TIMEOUT = 64,
   parameter bit ZERO_WP = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   arith_op_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_I = 2'd1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   next_pc_q, next_pc_d;
   logic [1:0]        op_type_q, op_type_d;
   logic              op_sub_q, op_sub_d;
   logic [REG_AW-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [REG_AW-1:0] rs1_q, rs1_d;
   logic [REG_AW-1:0] rs2_q, rs2_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] add_a_q, add_a_d;
   logic [DATA_W-1:0] add_b_q, add_b_d;
   logic              add_stb_q, add_stb_d;
   logic              sum_busy_q, sum_busy_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   logic              finish;
   logic              abort;
   logic [DATA_W-1:0] b_raw;
   logic [DATA_W-1:0] b_op;

   // Second operand: subtraction is done by flipping the sign bit of B,
   // which the floating-point adder turns into A-B.
   assign b_raw = (op_type_q == OP_I) ? imm_q : bus.src2_val;
   assign b_op  = {b_raw[DATA_W-1] ^ op_sub_q, b_raw[DATA_W-2:0]};

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         next_pc_q  <= '0;
         op_type_q  <= '0;
         op_sub_q   <= 1'b0;
         dst_q      <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         wr_data_q  <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_stb_q  <= 1'b0;
         sum_busy_q <= 1'b1;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         next_pc_q  <= next_pc_d;
         op_type_q  <= op_type_d;
         op_sub_q   <= op_sub_d;
         dst_q      <= dst_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         wr_data_q  <= wr_data_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_stb_q  <= add_stb_d;
         sum_busy_q <= sum_busy_d;
         tmo_q      <= tmo_d;
      end
   end

   // ----------------------------------------------- next state / outputs
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      next_pc_d  = next_pc_q;
      op_type_d  = op_type_q;
      op_sub_d   = op_sub_q;
      dst_d      = dst_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      wr_data_d  = wr_data_q;
      we_d       = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      add_stb_d  = add_stb_q;
      sum_busy_d = sum_busy_q;
      tmo_d      = tmo_q;
      finish     = 1'b0;
      abort      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Decode inputs are captured only here; later changes are ignored.
            if (bus.start) begin
               pc_d      = bus.pc;
               op_type_d = bus.op_type;
               op_sub_d  = bus.op_sub;
               dst_d     = bus.dst_addr;
               imm_d     = bus.imm;
               rs1_d     = bus.src1_addr;
               rs2_d     = bus.src2_addr;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               state_d   = S_READ;
            end
         end

         S_READ: begin
            if (op_type_q[1]) begin
               // Illegal opcode: finish with error, adder never touched.
               err_d  = 1'b1;
               finish = 1'b1;
            end else begin
               add_a_d   = bus.src1_val;
               add_b_d   = b_op;
               add_stb_d = 1'b1;
               tmo_d     = '0;
               state_d   = S_ISSUE;
            end
         end

         S_ISSUE: begin
            // A completing handshake wins over the timeout on the same edge
            // so an accepted transfer is never silently dropped.
            if (add_stb_q && !bus.add_busy) begin
               add_stb_d  = 1'b0;
               sum_busy_d = 1'b0;
               tmo_d      = tmo_q + 1'b1;
               state_d    = S_WAIT;
            end else if (tmo_q >= TMO_LAST) begin
               abort = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         S_WAIT: begin
            if (bus.sum_stb && !sum_busy_q) begin
               sum_busy_d = 1'b1;
               rd_d       = dst_q;
               wr_data_d  = bus.sum;
               we_d       = !(ZERO_WP && (dst_q == '0));
               state_d    = S_WRITE;
            end else if (tmo_q >= TMO_LAST) begin
               abort = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         S_WRITE: begin
            finish = 1'b1;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort) begin
         add_stb_d  = 1'b0;
         sum_busy_d = 1'b1;
         err_d      = 1'b1;
         finish     = 1'b1;
      end

      // Every path into DONE (normal, illegal opcode, timeout) shares this.
      if (finish) begin
         state_d   = S_DONE;
         busy_d    = 1'b0;
         done_d    = 1'b1;
         next_pc_d = pc_q + 1'b1;
      end
   end

   // ------------------------------------------------------------- outputs
   assign bus.next_pc  = next_pc_q;
   assign bus.rs1      = rs1_q;
   assign bus.rs2      = rs2_q;
   assign bus.rd       = rd_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.we       = we_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.add_a    = add_a_q;
   assign bus.add_b    = add_b_q;
   assign bus.add_stb  = add_stb_q;
   assign bus.sum_busy = sum_busy_q;

endmodule

// File: tb/tb_arith_op_controller.sv
// -----------------------------------------------------------------------------
// tb_arith_op_controller
// Directed bench for arith_op_controller: a small register file, an adder
// responder with programmable input stall and result latency, and a linear
// sequence of operations with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_arith_op_controller;
   localparam int DATA_W  = 32;
   localparam int REG_AW  = 5;
   localparam int PC_W    = 5;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   arith_op_controller_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) bus ();

   arith_op_controller #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .PC_W   (PC_W),
      .TIMEOUT(TIMEOUT),
      .ZERO_WP(1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // register file, combinational read
   logic [DATA_W-1:0] regs [0:31];
   assign bus.src1_val = regs[bus.rs1];
   assign bus.src2_val = regs[bus.rs2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;
   int lat      = 0;

   // transaction bookkeeping
   int                xfer_cnt, we_cnt, stb_cycles, stall_edges;
   logic [DATA_W-1:0] cap_a, cap_b, cap_wd;
   logic [REG_AW-1:0] cap_rd;
   bit                pend;
   int                lat_left, lat_cfg, stall_left;
   bit                never_resp;
   logic [DATA_W-1:0] result_cfg;
   int                xfer_snap;

   // Edge monitor: sees pre-edge values of every handshake.
   always @(posedge clk) begin
      cyc++;
      if (bus.add_stb) stb_cycles++;
      if (bus.add_stb && bus.add_busy) stall_edges++;
      if (bus.add_stb && !bus.add_busy) begin
         xfer_cnt++;
         cap_a    = bus.add_a;
         cap_b    = bus.add_b;
         pend     = 1'b1;
         lat_left = lat_cfg;
      end
      if (bus.sum_stb && !bus.sum_busy) pend = 1'b0;
      if (bus.we) begin
         we_cnt++;
         cap_rd = bus.rd;
         cap_wd = bus.wr_data;
      end
   end

   // Adder responder, driven on the falling edge.
   always @(negedge clk) begin
      bus.add_busy = (stall_left > 0);
      if (bus.add_stb && stall_left > 0) stall_left--;
      if (pend && !never_resp) begin
         if (lat_left > 0) begin
            bus.sum_stb = 1'b0;
            lat_left--;
         end else begin
            bus.sum_stb = 1'b1;
            bus.sum     = result_cfg;
         end
      end else begin
         bus.sum_stb = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic prep(input int stall, input int l, input bit never, input logic [31:0] res);
      stall_left  = stall;
      lat_cfg     = l;
      never_resp  = never;
      result_cfg  = res;
      pend        = 1'b0;
      xfer_cnt    = 0;
      we_cnt      = 0;
      stb_cycles  = 0;
      stall_edges = 0;
   endtask

   // Called on a falling edge in IDLE; returns on the falling edge of READ.
   task automatic start_op(input logic [1:0] t, input logic s, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] d,
                           input logic [31:0] im, input logic [4:0] p);
      bus.start     = 1'b1;
      bus.op_type   = t;
      bus.op_sub    = s;
      bus.src1_addr = a1;
      bus.src2_addr = a2;
      bus.dst_addr  = d;
      bus.imm       = im;
      bus.pc        = p;
      t0            = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Returns on the falling edge of the cycle where done is high; lat=-1 on expiry.
   task automatic wait_done(input int budget, output int l);
      l = -1;
      for (int i = 0; i < budget; i++) begin
         if (bus.done === 1'b1) begin
            l = cyc - t0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic show(input string tag);
      $display("op %s: rd=%0d wr_data=0x%08h we_pulses=%0d next_pc=%0d err=%0b latency=%0d",
               tag, cap_rd, cap_wd, we_cnt, bus.next_pc, bus.err, lat);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.op_type   = 2'd0;
      bus.op_sub    = 1'b0;
      bus.src1_addr = '0;
      bus.src2_addr = '0;
      bus.dst_addr  = '0;
      bus.imm       = '0;
      bus.pc        = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h0000_0000;
      prep(0, 0, 1'b0, 32'h0);
      cap_rd = '0;
      cap_wd = '0;
      @(negedge clk);
      @(negedge clk);

      // ---- reset values
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_done",     32'(bus.done),     32'd0);
      check("rst_err",      32'(bus.err),      32'd0);
      check("rst_we",       32'(bus.we),       32'd0);
      check("rst_add_stb",  32'(bus.add_stb),  32'd0);
      check("rst_sum_busy", 32'(bus.sum_busy), 32'd1);
      check("rst_next_pc",  32'(bus.next_pc),  32'd0);
      check("rst_rd",       32'(bus.rd),       32'd0);
      check("rst_rs1",      32'(bus.rs1),      32'd0);
      check("rst_wr_data",  bus.wr_data,       32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- R-add: 1.5 + 2.25 = 3.75, adder latency 3
      regs[1] = 32'h3FC0_0000;
      regs[2] = 32'h4010_0000;
      prep(0, 3, 1'b0, 32'h4070_0000);
      start_op(2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 5'd4);
      check("radd_busy_read", 32'(bus.busy), 32'd1);
      check("radd_rs1", 32'(bus.rs1), 32'd1);
      check("radd_rs2", 32'(bus.rs2), 32'd2);
      wait_done(40, lat);
      check("radd_latency", 32'(lat), 32'd8);
      check("radd_add_a",   cap_a, 32'h3FC0_0000);
      check("radd_add_b",   cap_b, 32'h4010_0000);
      check("radd_xfers",   32'(xfer_cnt), 32'd1);
      check("radd_we_cnt",  32'(we_cnt), 32'd1);
      check("radd_rd",      32'(cap_rd), 32'd3);
      check("radd_wr_data", cap_wd, 32'h4070_0000);
      check("radd_next_pc", 32'(bus.next_pc), 32'd5);
      check("radd_err",     32'(bus.err), 32'd0);
      check("radd_busy_done", 32'(bus.busy), 32'd0);
      show("R-add");
      @(negedge clk);
      check("radd_done_pulse", 32'(bus.done), 32'd0);
      check("radd_wr_hold", bus.wr_data, 32'h4070_0000);

      // ---- I-sub back-to-back: 2.25 - 1.5 = 0.75, zero latency;
      //      decode inputs scrambled after acceptance
      regs[5] = 32'h4010_0000;
      prep(0, 0, 1'b0, 32'h3F40_0000);
      start_op(2'd1, 1'b1, 5'd5, 5'd2, 5'd7, 32'h3FC0_0000, 5'd10);
      bus.imm     = 32'h1234_5678;
      bus.op_type = 2'd2;
      bus.op_sub  = 1'b0;
      wait_done(40, lat);
      check("isub_latency", 32'(lat), 32'd5);
      check("isub_add_a",   cap_a, 32'h4010_0000);
      check("isub_add_b",   cap_b, 32'hBFC0_0000);
      check("isub_wr_data", cap_wd, 32'h3F40_0000);
      check("isub_rd",      32'(cap_rd), 32'd7);
      check("isub_next_pc", 32'(bus.next_pc), 32'd11);
      check("isub_err",     32'(bus.err), 32'd0);
      show("I-sub");
      @(negedge clk);

      // ---- stalled adder (10 cycles busy, latency 3) + start while busy
      regs[4] = 32'h4000_0000;
      regs[6] = 32'h4040_0000;
      prep(10, 3, 1'b0, 32'h40A0_0000);
      start_op(2'd0, 1'b0, 5'd4, 5'd6, 5'd8, 32'h0, 5'd20);
      bus.start     = 1'b1;
      bus.dst_addr  = 5'd9;
      bus.src1_addr = 5'd1;
      bus.pc        = 5'd0;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(80, lat);
      check("stall_latency",  32'(lat), 32'd18);
      check("stall_stb_cyc",  32'(stb_cycles), 32'd11);
      check("stall_edges",    32'(stall_edges), 32'd10);
      check("stall_xfers",    32'(xfer_cnt), 32'd1);
      check("stall_add_a",    cap_a, 32'h4000_0000);
      check("stall_rd",       32'(cap_rd), 32'd8);
      check("stall_wr_data",  cap_wd, 32'h40A0_0000);
      check("stall_we_cnt",   32'(we_cnt), 32'd1);
      check("stall_next_pc",  32'(bus.next_pc), 32'd21);
      show("stall");
      @(negedge clk);

      // ---- adder never answers, pc wraps 31 -> 0
      prep(0, 0, 1'b1, 32'h0);
      start_op(2'd0, 1'b0, 5'd1, 5'd2, 5'd5, 32'h0, 5'd31);
      wait_done(120, lat);
      check("tmo_latency",  32'(lat), 32'(TIMEOUT + 2));
      check("tmo_err",      32'(bus.err), 32'd1);
      check("tmo_we_cnt",   32'(we_cnt), 32'd0);
      check("tmo_next_pc",  32'(bus.next_pc), 32'd0);
      check("tmo_sum_busy", 32'(bus.sum_busy), 32'd1);
      check("tmo_add_stb",  32'(bus.add_stb), 32'd0);
      show("timeout");
      @(negedge clk);
      check("tmo_done_pulse", 32'(bus.done), 32'd0);
      check("tmo_err_hold",   32'(bus.err), 32'd1);
      check("tmo_rd_hold",    32'(bus.rd), 32'd8);

      // ---- illegal op_type
      prep(0, 0, 1'b0, 32'h0);
      start_op(2'd2, 1'b0, 5'd1, 5'd2, 5'd4, 32'h0, 5'd7);
      check("ill_err_clear", 32'(bus.err), 32'd0);
      wait_done(10, lat);
      check("ill_latency", 32'(lat), 32'd2);
      check("ill_err",     32'(bus.err), 32'd1);
      check("ill_stb",     32'(stb_cycles), 32'd0);
      check("ill_we_cnt",  32'(we_cnt), 32'd0);
      check("ill_next_pc", 32'(bus.next_pc), 32'd8);
      show("illegal");
      @(negedge clk);

      // ---- write to r0 suppressed
      prep(0, 1, 1'b0, 32'h4070_0000);
      start_op(2'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 5'd12);
      check("r0_err_clear", 32'(bus.err), 32'd0);
      wait_done(40, lat);
      check("r0_latency", 32'(lat), 32'd6);
      check("r0_we_cnt",  32'(we_cnt), 32'd0);
      check("r0_xfers",   32'(xfer_cnt), 32'd1);
      check("r0_err",     32'(bus.err), 32'd0);
      check("r0_next_pc", 32'(bus.next_pc), 32'd13);
      show("r0-write");
      @(negedge clk);

      // ---- reset asserted during WAIT
      prep(0, 0, 1'b1, 32'h4070_0000);
      start_op(2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 5'd2);
      @(negedge clk);
      @(negedge clk);
      check("wrst_in_wait", 32'(bus.sum_busy), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("wrst_busy",     32'(bus.busy),     32'd0);
      check("wrst_done",     32'(bus.done),     32'd0);
      check("wrst_err",      32'(bus.err),      32'd0);
      check("wrst_we",       32'(bus.we),       32'd0);
      check("wrst_add_stb",  32'(bus.add_stb),  32'd0);
      check("wrst_sum_busy", 32'(bus.sum_busy), 32'd1);
      check("wrst_next_pc",  32'(bus.next_pc),  32'd0);
      check("wrst_rs1",      32'(bus.rs1),      32'd0);
      check("wrst_wr_data",  bus.wr_data,       32'h0);
      never_resp = 1'b0;
      xfer_snap  = xfer_cnt;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("wrst_no_we",    32'(we_cnt), 32'd0);
      check("wrst_no_xfer",  32'(xfer_cnt), 32'(xfer_snap));
      check("wrst_idle",     32'(bus.busy), 32'd0);
      lat = 0;
      show("reset-in-wait");

      // ---- recovery after reset
      prep(0, 1, 1'b0, 32'h4070_0000);
      start_op(2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 5'd0);
      wait_done(40, lat);
      check("rec_latency", 32'(lat), 32'd6);
      check("rec_we_cnt",  32'(we_cnt), 32'd1);
      check("rec_wr_data", cap_wd, 32'h4070_0000);
      check("rec_next_pc", 32'(bus.next_pc), 32'd1);
      show("recovery");
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
